// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep voter: OBI request record, voter state
// encoding and the request equality rule used by every bus vote.
package lockstep_pkg;

    localparam int NHARTS_MAX = 3;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef enum logic [1:0] {
        VS_NORMAL   = 2'd0,
        VS_DEGRADED = 2'd1,
        VS_HALT     = 2'd2
    } voter_state_e;

    // Two requests agree when their control bits match; addr only matters
    // when both are requesting and wdata only when both are writing.
    function automatic logic req_eq(input obi_req_t a, input obi_req_t b);
        logic same;
        same = (a.req == b.req) && (a.we == b.we) && (a.be == b.be);
        if (a.req && b.req && (a.addr != b.addr)) same = 1'b0;
        if (a.we && b.we && (a.wdata != b.wdata)) same = 1'b0;
        return same;
    endfunction

endpackage

// File: rtl/lockstep_bus_vote.sv
// Combinational vote for one OBI bus across the currently trusted harts.
// Three trusted harts: majority vote with single-outlier blame.
// Two trusted harts: straight comparison, any difference is a multi-fault.
module lockstep_bus_vote
    import lockstep_pkg::*;
#(
    parameter int NHARTS = 3
) (
    input  obi_req_t [NHARTS-1:0] reqs,
    input  logic [NHARTS-1:0]     active,
    output obi_req_t              voted,
    output logic                  mismatch,
    output logic [NHARTS-1:0]     blame,
    output logic                  multi
);

    localparam int IW = (NHARTS > 2) ? 2 : 1;

    logic [IW-1:0]     lo_idx;
    logic [IW-1:0]     hi_idx;
    logic              lo_found;
    logic [1:0]        n_active;
    logic              pair_eq;

    obi_req_t          maj_voted;
    logic              maj_mismatch;
    logic              maj_multi;
    logic [NHARTS-1:0] maj_blame;

    // Find the lowest and highest trusted harts and count them.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        lo_found = 1'b0;
        n_active = '0;
        for (int i = 0; i < NHARTS; i++) begin
            if (active[i]) begin
                n_active = n_active + 2'd1;
                if (!lo_found) begin
                    lo_idx   = IW'(i);
                    lo_found = 1'b1;
                end else begin
                    hi_idx = IW'(i);
                end
            end
        end
    end

    assign pair_eq = req_eq(reqs[lo_idx], reqs[hi_idx]);

    generate
        if (NHARTS == 3) begin : g_maj
            logic e01, e02, e12;
            assign e01 = req_eq(reqs[0], reqs[1]);
            assign e02 = req_eq(reqs[0], reqs[2]);
            assign e12 = req_eq(reqs[1], reqs[2]);

            // Equality is an equivalence here, so one true pair names the outlier.
            always_comb begin
                maj_voted    = '0;
                maj_mismatch = 1'b1;
                maj_blame    = '0;
                maj_multi    = 1'b0;
                if (e01 && e02) begin
                    maj_voted    = reqs[0];
                    maj_mismatch = 1'b0;
                end else if (e01) begin
                    maj_voted    = reqs[0];
                    maj_blame[2] = 1'b1;
                end else if (e02) begin
                    maj_voted    = reqs[0];
                    maj_blame[1] = 1'b1;
                end else if (e12) begin
                    maj_voted    = reqs[1];
                    maj_blame[0] = 1'b1;
                end else begin
                    maj_multi = 1'b1;
                end
            end
        end else begin : g_no_maj
            assign maj_voted    = '0;
            assign maj_mismatch = 1'b0;
            assign maj_blame    = '0;
            assign maj_multi    = 1'b0;
        end
    endgenerate

    // Choose majority or pairwise result by the size of the trusted set.
    always_comb begin
        voted    = '0;
        mismatch = 1'b0;
        blame    = '0;
        multi    = 1'b0;
        if (n_active == 2'd3) begin
            voted    = maj_voted;
            mismatch = maj_mismatch;
            blame    = maj_blame;
            multi    = maj_multi;
        end else if (n_active == 2'd2) begin
            if (pair_eq) begin
                voted = reqs[lo_idx];
            end else begin
                mismatch = 1'b1;
                blame    = active;
                multi    = 1'b1;
            end
        end else if (lo_found) begin
            voted = reqs[lo_idx];
        end
    end

endmodule

// File: rtl/lockstep_voter.sv
// Lockstep voter between NHARTS redundant cores and the single instr/data
// OBI masters. Votes combinationally and keeps sticky fault state.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   NORMAL   | all harts trusted; 3 harts mask one outlier, 2 harts detect
//   DEGRADED | one hart flagged; remaining pair compared, lower one forwarded
//   HALT     | buses gated to zero until fault_clear_i (encoding 3 alike)
module lockstep_voter
    import lockstep_pkg::*;
#(
    parameter int NHARTS = 3,
    parameter int CNT_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  obi_req_t [NHARTS-1:0] core_instr_req_i,
    output obi_req_t              voted_instr_req_o,
    input  obi_req_t [NHARTS-1:0] core_data_req_i,
    output obi_req_t              voted_data_req_o,
    input  logic                  fault_clear_i,
    output logic                  error_o,
    output logic [NHARTS-1:0]     fault_hart_o,
    output logic [CNT_W-1:0]      mismatch_cnt_o,
    output logic [1:0]            state_o,
    output logic                  halt_o
);

    localparam logic [1:0] ST_NORMAL   = VS_NORMAL;
    localparam logic [1:0] ST_DEGRADED = VS_DEGRADED;
    localparam logic [1:0] ST_HALT     = VS_HALT;

    generate
        if (NHARTS < 2 || NHARTS > NHARTS_MAX) begin : g_bad_nharts
            $error("lockstep_voter: NHARTS must be 2 or 3");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic              halt_q;
    logic [NHARTS-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    obi_req_t          instr_voted, data_voted;
    logic              instr_mis, data_mis;
    logic              instr_multi, data_multi;
    logic [NHARTS-1:0] instr_blame, data_blame;
    logic              error;
    logic              multi_fault;
    logic              in_halt;
    logic              gate;

    lockstep_bus_vote #(.NHARTS(NHARTS)) u_instr_vote (
        .reqs     (core_instr_req_i),
        .active   (~flags_q),
        .voted    (instr_voted),
        .mismatch (instr_mis),
        .blame    (instr_blame),
        .multi    (instr_multi)
    );

    lockstep_bus_vote #(.NHARTS(NHARTS)) u_data_vote (
        .reqs     (core_data_req_i),
        .active   (~flags_q),
        .voted    (data_voted),
        .mismatch (data_mis),
        .blame    (data_blame),
        .multi    (data_multi)
    );

    // A single-fault verdict needs both buses to blame the same hart.
    assign error       = instr_mis | data_mis;
    assign multi_fault = instr_multi | data_multi |
                         (instr_mis & data_mis & (instr_blame != data_blame));
    assign in_halt     = (state_q == ST_HALT) || (state_q == 2'd3);
    assign gate        = in_halt | multi_fault;

    assign voted_instr_req_o = gate ? '0 : instr_voted;
    assign voted_data_req_o  = gate ? '0 : data_voted;
    assign error_o           = error;
    assign fault_hart_o      = flags_q;
    assign mismatch_cnt_o    = cnt_q;
    assign state_o           = state_q;
    assign halt_o            = halt_q;

    // Next-state, flag and counter update; clear overrides everything else.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (error && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (in_halt) begin
            state_d = ST_HALT;
        end else if (error) begin
            flags_d = flags_q | instr_blame | data_blame;
            state_d = multi_fault ? ST_HALT : ST_DEGRADED;
        end
        if (fault_clear_i) begin
            state_d = ST_NORMAL;
            flags_d = '0;
            cnt_d   = error ? CNT_W'(1) : '0;
        end
    end

    // Fault state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_NORMAL;
            halt_q  <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == ST_HALT);
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lockstep_voter.sv
// Bench for lockstep_voter: a 3-hart instance (8-bit counter), a 3-hart
// twin with a 2-bit counter on the same inputs, and a 2-hart instance.
module tb_lockstep_voter;
    import lockstep_pkg::*;

    typedef obi_req_t [2:0] trio_t;

    typedef struct {
        string      name;
        bit         tgt2;
        trio_t      ins;
        trio_t      dat;
        bit         clr;
        obi_req_t   exp_vi;
        obi_req_t   exp_vd;
        bit         exp_err;
        logic [1:0] exp_st;
        logic [2:0] exp_fl;
        bit         chk_fl;
        int         exp_cnt;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst;

    trio_t    d3_instr, d3_data;
    logic     d3_clear;
    obi_req_t [1:0] d2_instr, d2_data;
    logic     d2_clear;

    obi_req_t d3_vi, d3_vd, dc_vi, dc_vd, d2_vi, d2_vd;
    logic     d3_err, dc_err, d2_err;
    logic [2:0] d3_fl, dc_fl;
    logic [1:0] d2_fl;
    logic [7:0] d3_cnt, d2_cnt;
    logic [1:0] dc_cnt;
    logic [1:0] d3_st, dc_st, d2_st;
    logic     d3_halt, dc_halt, d2_halt;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    lockstep_voter #(.NHARTS(3), .CNT_W(8)) d3 (
        .clk_i(clk), .rst_i(rst),
        .core_instr_req_i(d3_instr), .voted_instr_req_o(d3_vi),
        .core_data_req_i(d3_data), .voted_data_req_o(d3_vd),
        .fault_clear_i(d3_clear), .error_o(d3_err), .fault_hart_o(d3_fl),
        .mismatch_cnt_o(d3_cnt), .state_o(d3_st), .halt_o(d3_halt)
    );

    lockstep_voter #(.NHARTS(3), .CNT_W(2)) dc (
        .clk_i(clk), .rst_i(rst),
        .core_instr_req_i(d3_instr), .voted_instr_req_o(dc_vi),
        .core_data_req_i(d3_data), .voted_data_req_o(dc_vd),
        .fault_clear_i(d3_clear), .error_o(dc_err), .fault_hart_o(dc_fl),
        .mismatch_cnt_o(dc_cnt), .state_o(dc_st), .halt_o(dc_halt)
    );

    lockstep_voter #(.NHARTS(2), .CNT_W(8)) d2 (
        .clk_i(clk), .rst_i(rst),
        .core_instr_req_i(d2_instr), .voted_instr_req_o(d2_vi),
        .core_data_req_i(d2_data), .voted_data_req_o(d2_vd),
        .fault_clear_i(d2_clear), .error_o(d2_err), .fault_hart_o(d2_fl),
        .mismatch_cnt_o(d2_cnt), .state_o(d2_st), .halt_o(d2_halt)
    );

    function automatic obi_req_t rq(input logic req, input logic we,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_t r;
        r.req   = req;
        r.we    = we;
        r.be    = 4'hF;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic trio_t trio(input obi_req_t h0, input obi_req_t h1, input obi_req_t h2);
        return {h2, h1, h0};
    endfunction

    function automatic vec_t mk(input string nm, input bit tgt2, input trio_t ins,
                                input trio_t dat, input bit clr, input obi_req_t evi,
                                input obi_req_t evd, input bit eerr, input logic [1:0] est,
                                input logic [2:0] efl, input bit cfl, input int ecnt);
        vec_t v;
        v.name = nm;   v.tgt2 = tgt2;  v.ins = ins;     v.dat = dat;
        v.clr = clr;   v.exp_vi = evi; v.exp_vd = evd;  v.exp_err = eerr;
        v.exp_st = est; v.exp_fl = efl; v.chk_fl = cfl; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t c;
        @(negedge clk);
        if (v.tgt2) begin
            d2_instr = v.ins[1:0];
            d2_data  = v.dat[1:0];
            d2_clear = v.clr;
        end else begin
            d3_instr = v.ins;
            d3_data  = v.dat;
            d3_clear = v.clr;
        end
        sb.push_back(v);
        #1;
        c = sb[0];
        if (c.tgt2) begin
            chk({c.name, "/vi"},  70'(d2_vi),  70'(c.exp_vi));
            chk({c.name, "/vd"},  70'(d2_vd),  70'(c.exp_vd));
            chk({c.name, "/err"}, 70'(d2_err), 70'(c.exp_err));
        end else begin
            chk({c.name, "/vi"},  70'(d3_vi),  70'(c.exp_vi));
            chk({c.name, "/vd"},  70'(d3_vd),  70'(c.exp_vd));
            chk({c.name, "/err"}, 70'(d3_err), 70'(c.exp_err));
        end
        @(posedge clk);
        #1;
        c = sb.pop_front();
        if (c.tgt2) begin
            chk({c.name, "/st"},   70'(d2_st),   70'(c.exp_st));
            chk({c.name, "/halt"}, 70'(d2_halt), 70'(c.exp_st == 2'd2));
            if (c.chk_fl) chk({c.name, "/fl"}, 70'(d2_fl), 70'(c.exp_fl[1:0]));
            chk({c.name, "/cnt"},  70'(d2_cnt),  70'(c.exp_cnt));
        end else begin
            chk({c.name, "/st"},   70'(d3_st),   70'(c.exp_st));
            chk({c.name, "/halt"}, 70'(d3_halt), 70'(c.exp_st == 2'd2));
            if (c.chk_fl) chk({c.name, "/fl"}, 70'(d3_fl), 70'(c.exp_fl));
            chk({c.name, "/cnt"},  70'(d3_cnt),  70'(c.exp_cnt));
            chk({c.name, "/c_st"}, 70'(dc_st),   70'(c.exp_st));
            chk({c.name, "/c_cnt"}, 70'(dc_cnt), 70'((c.exp_cnt > 3) ? 3 : c.exp_cnt));
        end
        d3_clear = 1'b0;
        d2_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obi_req_t R0, R1, R2, R84, W, W2, W3, WN, DA, DB, Q0, Q1, Z;
        trio_t    RR, WW, W3W;
        int       split;

        R0  = rq(1'b1, 1'b0, 32'h80, 32'h0);
        R1  = rq(1'b1, 1'b0, 32'h80, 32'h11);
        R2  = rq(1'b1, 1'b0, 32'h80, 32'h22);
        R84 = rq(1'b1, 1'b0, 32'h84, 32'h0);
        W   = rq(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF);
        W2  = rq(1'b1, 1'b1, 32'h1000, 32'hDEADBEEE);
        W3  = rq(1'b1, 1'b1, 32'h1000, 32'hDEADBEED);
        WN  = rq(1'b1, 1'b0, 32'h1000, 32'hDEADBEEF);
        DA  = rq(1'b1, 1'b0, 32'h2000, 32'h0);
        DB  = rq(1'b1, 1'b0, 32'h2004, 32'h0);
        Q0  = rq(1'b0, 1'b0, 32'h0, 32'h0);
        Q1  = rq(1'b0, 1'b0, 32'hFFFF, 32'h0);
        Z   = '0;
        RR  = trio(R0, R0, R0);
        WW  = trio(W, W, W);
        W3W = trio(W, W2, W3);

        // 3-hart path up to DEGRADED
        vecs.push_back(mk("eq_write", 0, RR, WW, 0, R0, W, 1, 2'd0, 3'b000, 1, 0));
        vecs[0].exp_err = 1'b0;
        vecs.push_back(mk("h2_wdata", 0, RR, trio(W, W, W2), 0, R0, W, 1, 2'd1, 3'b100, 1, 1));
        split = vecs.size();
        // DEGRADED -> HALT -> clear, outlier hart 0, counter, conflicting blame
        vecs.push_back(mk("h1_addr", 0, RR, trio(DA, DB, W), 0, Z, Z, 1, 2'd2, 3'b111, 1, 2));
        vecs.push_back(mk("halt_ign", 0, RR, trio(W, W2, W), 0, Z, Z, 0, 2'd2, 3'b111, 1, 2));
        vecs.push_back(mk("clear", 0, RR, WW, 1, Z, Z, 0, 2'd0, 3'b000, 1, 0));
        vecs.push_back(mk("h0_instr", 0, trio(R84, R1, R2), WW, 0, R1, W, 1, 2'd1, 3'b001, 1, 1));
        vecs.push_back(mk("deg_h0_ign", 0, trio(R84, R1, R2), trio(W2, W, W), 0, R1, W, 0, 2'd1, 3'b001, 1, 1));
        vecs.push_back(mk("clear_deg", 0, RR, WW, 1, R0, W, 0, 2'd0, 3'b000, 1, 0));
        for (int k = 1; k <= 6; k++)
            vecs.push_back(mk($sformatf("cnt%0d", k), 0, RR, W3W, 0, Z, Z, 1, 2'd2, 3'b000, 1, k));
        vecs.push_back(mk("clear_err", 0, RR, W3W, 1, Z, Z, 1, 2'd0, 3'b000, 1, 1));
        vecs.push_back(mk("normal_again", 0, RR, WW, 0, R0, W, 0, 2'd0, 3'b000, 1, 1));
        vecs.push_back(mk("conflict", 0, trio(R84, R0, R0), trio(W, W2, W), 0, Z, Z, 1, 2'd2, 3'b000, 0, 2));
        // 2-hart instance
        vecs.push_back(mk("d2_req0", 1, trio(Q0, Q1, Z), trio(W, W, Z), 0, Q0, W, 0, 2'd0, 3'b000, 1, 0));
        vecs.push_back(mk("d2_we", 1, trio(R0, R0, Z), trio(W, WN, Z), 0, Z, Z, 1, 2'd2, 3'b011, 1, 1));
        vecs.push_back(mk("d2_halt", 1, trio(R0, R0, Z), trio(W, W, Z), 0, Z, Z, 0, 2'd2, 3'b011, 1, 1));
        vecs.push_back(mk("d2_clear", 1, trio(R0, R0, Z), trio(W, W, Z), 1, Z, Z, 0, 2'd0, 3'b000, 1, 0));
        vecs.push_back(mk("d2_eq", 1, trio(R0, R0, Z), trio(W, W, Z), 0, R0, W, 0, 2'd0, 3'b000, 1, 0));

        rst      = 1'b1;
        d3_instr = '0;
        d3_data  = '0;
        d3_clear = 1'b0;
        d2_instr = '0;
        d2_data  = '0;
        d2_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/st",    70'(d3_st),   70'(0));
        chk("rst/halt",  70'(d3_halt), 70'(0));
        chk("rst/fl",    70'(d3_fl),   70'(0));
        chk("rst/cnt",   70'(d3_cnt),  70'(0));
        chk("rst/d2_st", 70'(d2_st),   70'(0));
        chk("rst/d2_fl", 70'(d2_fl),   70'(0));
        rst = 1'b0;

        for (int i = 0; i < split; i++) run_vec(vecs[i]);

        // hart 2 flagged: its garbage is ignored, hart 0 forwarded even when
        // hart 1 carries a different (don't-care) wdata
        for (int k = 0; k < 10; k++) begin
            logic [95:0] rnd_i, rnd_d;
            obi_req_t    gi, gd, d0, d1;
            rnd_i = {$urandom, $urandom, $urandom};
            rnd_d = {$urandom, $urandom, $urandom};
            gi = rnd_i[69:0];
            gd = rnd_d[69:0];
            d0 = rq(1'b1, 1'b0, 32'h2000, $urandom);
            d1 = rq(1'b1, 1'b0, 32'h2000, $urandom);
            run_vec(mk($sformatf("garbage%0d", k), 0, trio(R0, R0, gi), trio(d0, d1, gd), 0,
                       R0, d0, 0, 2'd1, 3'b100, 1, 1));
        end

        for (int i = split; i < vecs.size(); i++) run_vec(vecs[i]);

        // reset while the 3-hart instances sit in HALT
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_halt/st",    70'(d3_st),   70'(0));
        chk("rst_halt/halt",  70'(d3_halt), 70'(0));
        chk("rst_halt/fl",    70'(d3_fl),   70'(0));
        chk("rst_halt/cnt",   70'(d3_cnt),  70'(0));
        chk("rst_halt/c_cnt", 70'(dc_cnt),  70'(0));
        chk("rst_halt/c_st",  70'(dc_st),   70'(0));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
